// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared types and widths for the MMIO bus arbiter: FSM states, bus owner codes
// and the latched bus payload.
package mmio_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } arbStateT;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_CORE = 2'b01,
        OWNER_DBG  = 2'b10
    } busOwnerT;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wrEn;
    } memBusT;

endpackage

// File: rtl/mmio_arb_prio.sv
// Winner select between core and debug requesters. With MMIO_ARB_FAIR_EN defined
// a starvation counter forces a debug grant after STARVE_LIMIT core wins.
module mmio_arb_prio
    import mmio_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arbEn,
    input  logic cReq,
    input  logic dReq,
    output logic grantCore_c,
    output logic grantDbg_c
);

`ifdef MMIO_ARB_FAIR_EN
    logic [3:0] starveCnt;
    logic       forceDbg;

    assign forceDbg    = (starveCnt == 4'(STARVE_LIMIT));
    assign grantCore_c = arbEn && cReq && !(dReq && forceDbg);
    assign grantDbg_c  = arbEn && dReq && (!cReq || forceDbg);

    // Counts core wins taken while debug waits; any debug win clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (grantDbg_c) begin
            starveCnt <= '0;
        end else if (grantCore_c && dReq) begin
            starveCnt <= starveCnt + 4'd1;
        end
    end
`else
    logic unusedFair;

    assign unusedFair  = ^{clk, rst, 4'(STARVE_LIMIT)};
    assign grantCore_c = arbEn && cReq;
    assign grantDbg_c  = arbEn && dReq && !cReq;
`endif

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-port MMIO bus arbiter/sequencer: IDLE -> ACCESS -> DONE per transaction.
// Optional debug-port fairness is compiled in with MMIO_ARB_FAIR_EN.
module mmio_bus_arbiter
    import mmio_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cReq,
    input  logic [ADDR_W-1:0] i_cAddr,
    input  logic [DATA_W-1:0] i_cData,
    input  logic              i_cWrEn,
    output logic              o_cAck,
    output logic [DATA_W-1:0] o_cData,
    input  logic              i_dReq,
    input  logic [ADDR_W-1:0] i_dAddr,
    input  logic [DATA_W-1:0] i_dData,
    input  logic              i_dWrEn,
    output logic              o_dAck,
    output logic [DATA_W-1:0] o_dData,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [DATA_W-1:0] o_memDataIn,
    output logic              o_memWrEn,
    input  logic [DATA_W-1:0] i_memDataOut,
    output logic [1:0]        o_busOwner
);

    arbStateT          state, stateNext;
    busOwnerT          owner, ownerNext;
    memBusT            bus, busNext;
    logic              cAck, cAckNext;
    logic              dAck, dAckNext;
    logic [DATA_W-1:0] cData, cDataNext;
    logic [DATA_W-1:0] dData, dDataNext;
    logic              grantCore_c;
    logic              grantDbg_c;

    mmio_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) uPrio (
        .clk        (i_clk),
        .rst        (i_rst),
        .arbEn      (state == IDLE),
        .cReq       (i_cReq),
        .dReq       (i_dReq),
        .grantCore_c(grantCore_c),
        .grantDbg_c (grantDbg_c)
    );

    // The bus register doubles as the request latch: loaded on grant, zero otherwise.
    always_comb begin
        stateNext = state;
        ownerNext = owner;
        busNext   = '0;
        cAckNext  = 1'b0;
        dAckNext  = 1'b0;
        cDataNext = cData;
        dDataNext = dData;
        case (state)
            IDLE: begin
                if (grantCore_c) begin
                    stateNext = ACCESS;
                    ownerNext = OWNER_CORE;
                    busNext   = '{addr: i_cAddr, data: i_cData, wrEn: i_cWrEn};
                end else if (grantDbg_c) begin
                    stateNext = ACCESS;
                    ownerNext = OWNER_DBG;
                    busNext   = '{addr: i_dAddr, data: i_dData, wrEn: i_dWrEn};
                end
            end
            ACCESS: begin
                stateNext = DONE;
                if (owner == OWNER_DBG) begin
                    dDataNext = i_memDataOut;
                    dAckNext  = 1'b1;
                end else begin
                    cDataNext = i_memDataOut;
                    cAckNext  = 1'b1;
                end
            end
            DONE: begin
                stateNext = IDLE;
                ownerNext = OWNER_NONE;
            end
            default: begin
                stateNext = IDLE;
                ownerNext = OWNER_NONE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            owner <= OWNER_NONE;
            bus   <= '0;
            cAck  <= 1'b0;
            dAck  <= 1'b0;
            cData <= '0;
            dData <= '0;
        end else begin
            state <= stateNext;
            owner <= ownerNext;
            bus   <= busNext;
            cAck  <= cAckNext;
            dAck  <= dAckNext;
            cData <= cDataNext;
            dData <= dDataNext;
        end
    end

    assign o_memAddr   = bus.addr;
    assign o_memDataIn = bus.data;
    assign o_memWrEn   = bus.wrEn;
    assign o_busOwner  = owner;
    assign o_cAck      = cAck;
    assign o_dAck      = dAck;
    assign o_cData     = cData;
    assign o_dData     = dData;

endmodule
